pc_redirect_ctrl: RTL and testbench

Next-PC sequencer for the 32-bit pipeline. It owns the fetch PC and resolves control transfers for the instruction in decode: j, jal, jr, bne, blt and bex. It sign-extends the 27-bit target field and the 17-bit immediate field internally. On a taken transfer it redirects the PC, then squashes the wrong-path slots already in the front end for a fixed number of cycles.

---
 rtl/pc_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: owns the fetch PC, resolves j/jal/jr/bne/blt/bex in decode,
// and squashes the wrong-path decode slots for FLUSH_CYCLES cycles after a redirect.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        dx_valid,
  input  logic [31:0] dx_insn,
  input  logic [31:0] dx_pc,
  input  logic        cmp_ne,
  input  logic        cmp_lt,
  input  logic        rstatus_nz,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        squash,
  output logic        redirect,
  output logic        link_valid,
  output logic [31:0] link_pc
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_BEX = 5'b10110;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [4:0]  opcode;
  logic [31:0] sx27;
  logic [31:0] sx17;
  logic [31:0] branch_target;
  logic        cond;
  logic        taken;
  logic        is_jal;
  logic [31:0] target;

  assign opcode        = dx_insn[31:27];
  assign sx27          = {{5{dx_insn[26]}}, dx_insn[26:0]};
  assign sx17          = {{15{dx_insn[16]}}, dx_insn[16:0]};
  assign branch_target = dx_pc + 32'd1 + sx17;
  assign is_jal        = (opcode == OP_JAL);
  assign taken         = dx_valid && cond;

  always_comb begin
    cond   = 1'b0;
    target = sx27;
    unique case (opcode)
      OP_J, OP_JAL: cond = 1'b1;
      OP_JR: begin
        cond   = 1'b1;
        target = jr_target;
      end
      OP_BNE: begin
        cond   = cmp_ne;
        target = branch_target;
      end
      OP_BLT: begin
        cond   = cmp_lt;
        target = branch_target;
      end
      OP_BEX:  cond = rstatus_nz;
      default: cond = 1'b0;
    endcase
  end

  // Stall freezes all architectural state; only the one-cycle pulses are cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      state      <= RUN;
      flush_cnt  <= 4'd0;
      squash     <= 1'b0;
      redirect   <= 1'b0;
      link_valid <= 1'b0;
      link_pc    <= 32'd0;
    end else if (stall) begin
      redirect   <= 1'b0;
      link_valid <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (taken) begin
            pc         <= target;
            redirect   <= 1'b1;
            state      <= FLUSH;
            flush_cnt  <= FLUSH_INIT;
            squash     <= 1'b1;
            link_valid <= is_jal;
            if (is_jal) link_pc <= dx_pc + 32'd1;
          end else begin
            pc         <= pc + 32'd1;
            redirect   <= 1'b0;
            squash     <= 1'b0;
            link_valid <= 1'b0;
          end
        end
        FLUSH: begin
          pc         <= pc + 32'd1;
          redirect   <= 1'b0;
          link_valid <= 1'b0;
          flush_cnt  <= flush_cnt - 4'd1;
          // Last squashed slot: return to RUN so the next decode slot is live.
          if (flush_cnt == 4'd1) begin
            state  <= RUN;
            squash <= 1'b0;
          end else begin
            squash <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: table of hand-computed vectors run
// through an expected-value queue, plus a stalled-jal sequence with a bounded wait.
module tb_pc_redirect_ctrl;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] dxpc;
    logic        ne;
    logic        lt;
    logic        nz;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic        e_sq;
    logic        e_rd;
    logic        e_lv;
    logic [31:0] e_lp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, stall, dx_valid, cmp_ne, cmp_lt, rstatus_nz;
  logic [31:0] dx_insn, dx_pc, jr_target;
  logic [31:0] pc, link_pc;
  logic        squash, redirect, link_valid;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BNE_M4 = 32'h1001_FFFC;
  localparam logic [31:0] JAL_NG = 32'h1C00_0010;
  localparam logic [31:0] BLT_5  = 32'h3000_0005;
  localparam logic [31:0] BEX_20 = 32'hB000_0020;
  localparam logic [31:0] JR     = 32'h2000_0000;
  localparam logic [31:0] J_M1   = 32'h0FFF_FFFF;
  localparam logic [31:0] J_23   = 32'h0800_0023;
  localparam logic [31:0] OP_BAD = 32'h3800_0000;
  localparam logic [31:0] BNE_0  = 32'h1000_0000;
  localparam logic [31:0] JAL_300 = 32'h1800_0300;

  pc_redirect_ctrl dut (
    .clock(clock), .reset(reset), .stall(stall), .dx_valid(dx_valid),
    .dx_insn(dx_insn), .dx_pc(dx_pc), .cmp_ne(cmp_ne), .cmp_lt(cmp_lt),
    .rstatus_nz(rstatus_nz), .jr_target(jr_target), .pc(pc), .squash(squash),
    .redirect(redirect), .link_valid(link_valid), .link_pc(link_pc)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rst, logic stl, logic vld, logic [31:0] insn,
                              logic [31:0] dxpc, logic ne, logic lt, logic nz,
                              logic [31:0] jrt, logic [31:0] e_pc, logic e_sq,
                              logic e_rd, logic e_lv, logic [31:0] e_lp);
    vec_t v;
    v.rst = rst; v.stall = stl; v.valid = vld; v.insn = insn; v.dxpc = dxpc;
    v.ne = ne; v.lt = lt; v.nz = nz; v.jrt = jrt;
    v.e_pc = e_pc; v.e_sq = e_sq; v.e_rd = e_rd; v.e_lv = e_lv; v.e_lp = e_lp;
    return v;
  endfunction

  task automatic check_field(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one vector's inputs and queue what the DUT must show after the next edge.
  task automatic applyStimulus(vec_t v);
    reset      = v.rst;
    stall      = v.stall;
    dx_valid   = v.valid;
    dx_insn    = v.insn;
    dx_pc      = v.dxpc;
    cmp_ne     = v.ne;
    cmp_lt     = v.lt;
    rstatus_nz = v.nz;
    jr_target  = v.jrt;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput(int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard vec %0d: queue empty", idx);
      return;
    end
    e = exp_q.pop_front();
    check_field("pc", idx, pc, e.e_pc);
    check_field("squash", idx, 32'(squash), 32'(e.e_sq));
    check_field("redirect", idx, 32'(redirect), 32'(e.e_rd));
    check_field("link_valid", idx, 32'(link_valid), 32'(e.e_lv));
    check_field("link_pc", idx, link_pc, e.e_lp);
  endtask

  initial begin
    // rst stl vld insn dx_pc ne lt nz jr_target | pc sq rd lv link_pc
    vecs.push_back(mk(1,0,0,NOP,0,0,0,0,0,            32'h0,0,0,0,32'h0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,          32'(i),0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,BNE_M4,32'h40,1,0,0,0,    32'h3D,1,1,0,32'h0));
    vecs.push_back(mk(0,0,1,BNE_M4,32'h40,1,0,0,0,    32'h3E,1,0,0,32'h0));
    vecs.push_back(mk(0,0,1,BNE_M4,32'h40,1,0,0,0,    32'h3F,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,JAL_NG,32'h100,0,0,0,0,   32'hFC00_0010,1,1,1,32'h101));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'hFC00_0011,1,0,0,32'h101));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'hFC00_0012,0,0,0,32'h101));
    vecs.push_back(mk(0,0,1,BLT_5,32'h10,0,0,0,0,     32'hFC00_0013,0,0,0,32'h101));
    vecs.push_back(mk(0,0,1,BEX_20,32'h10,0,0,0,0,    32'hFC00_0014,0,0,0,32'h101));
    vecs.push_back(mk(0,0,1,BLT_5,32'h10,0,1,0,0,     32'h16,1,1,0,32'h101));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h17,1,0,0,32'h101));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h18,0,0,0,32'h101));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,1,JR,32'h18,0,0,0,32'h200, 32'h18,0,0,0,32'h101));
    vecs.push_back(mk(0,0,1,JR,32'h18,0,0,0,32'h200,  32'h200,1,1,0,32'h101));
    vecs.push_back(mk(0,1,0,NOP,0,0,0,0,0,            32'h200,1,0,0,32'h101));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h201,1,0,0,32'h101));
    vecs.push_back(mk(1,0,1,JR,32'h18,0,0,0,32'h200,  32'h0,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,J_M1,32'h0,0,0,0,0,       32'hFFFF_FFFF,1,1,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h0,1,0,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h1,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,BEX_20,32'h1,0,0,1,0,     32'h20,1,1,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h21,1,0,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h22,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,J_23,32'h22,0,0,0,0,      32'h23,1,1,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h24,1,0,0,32'h0));
    vecs.push_back(mk(0,0,0,NOP,0,0,0,0,0,            32'h25,0,0,0,32'h0));
    vecs.push_back(mk(0,0,0,J_23,32'h25,0,0,0,0,      32'h26,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,OP_BAD,32'h26,1,1,1,0,    32'h27,0,0,0,32'h0));
    vecs.push_back(mk(0,0,1,BNE_0,32'h27,0,1,1,0,     32'h28,0,0,0,32'h0));
    // Stalled jal: pc and link state hold while stalled.
    vecs.push_back(mk(0,1,1,JAL_300,32'h50,0,0,0,0,   32'h28,0,0,0,32'h0));
    vecs.push_back(mk(0,1,1,JAL_300,32'h50,0,0,0,0,   32'h28,0,0,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput(i);
    end

    // Release the stall and wait, bounded, for the jal redirect.
    begin
      bit seen = 0;
      stall = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        @(posedge clock);
        #1;
        if (redirect) seen = 1;
        dx_valid = 1'b0;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("[TB] FAIL jal_release: redirect got 0 expected 1 within 4 cycles");
      end else begin
        check_field("jal_release_pc", 100, pc, 32'h300);
        check_field("jal_release_link_pc", 100, link_pc, 32'h51);
        check_field("jal_release_link_valid", 100, 32'(link_valid), 32'h1);
      end
      @(posedge clock);
      #1;
      check_field("jal_pulse_end", 101, 32'(link_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
